toggle_pulse_gen: RTL and testbench
===================================

// Module: toggle_pulse_gen
// PURPOSE
//   Generates the T (toggle-enable) strobe for the downstream T flip-flop stage.
//   Divides clk by a run-time period and emits 1-cycle T pulses, either free-running or as a counted burst.
//   Sits directly upstream of the T flip-flop; both share clk and rst.
// PARAMETERS
//   CNT_W   16  width of period input / prescale counter
//   LEN_W    8  width of burst-length input / pulse counter
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   en         in   1      1 = run; 0 = pause (counters frozen, t_out forced 0)
//   start      in   1      1-cycle request; accepted only in IDLE with en=1
//   stop       in   1      abort run; return to IDLE without done
//   mode       in   1      0 = periodic (until stop), 1 = burst (burst_len pulses)
//   div        in   CNT_W  pulse period in clk cycles; 0 treated as 1
//   burst_len  in   LEN_W  pulses per burst; 0 = immediate done, no pulses
//   t_out      out  1      registered T strobe to downstream flip-flop
//   busy       out  1      1 while in RUN
//   done       out  1      1-cycle pulse at burst completion
//   q_shadow   out  1      model of downstream Q (TOGGLE_PULSE_GEN_SHADOW_Q_EN only)
// BEHAVIOUR
//   - Reset (rst=1 at edge): state IDLE; t_out, busy, done, q_shadow = 0; counters = 0.
//     rst has priority over every other input; mid-run reset discards the run.
//   - FSM IDLE -> RUN -> DONE -> IDLE. All outputs registered.
//   - IDLE: start&en at edge N latches div_q = max(div,1), len_q = burst_len, mode_q.
//     Then busy=1 from edge N, prescale count = div_q-1, pulse count = 0.
//     In burst mode with len_q = 0, go straight to DONE (no RUN, no t_out).
//   - RUN: each edge with en=1 decrements prescale; at 0 reload div_q-1 and set t_out=1 for one cycle.
//     First pulse is high in the cycle after edge N+div_q; later pulses follow every div_q cycles.
//     With div_q=1, t_out stays high every cycle.
//   - en=0 in RUN: prescale frozen, t_out=0; resume continues the same count (no reload).
//   - Burst mode: after the len_q-th pulse, go to DONE. done=1 in the cycle after that pulse; busy=0 from the same edge.
//   - DONE lasts 1 cycle; returns to IDLE. start in the DONE cycle is ignored.
//   - stop in RUN: IDLE at the next edge, t_out=0, busy=0, no done. stop beats a coincident pulse.
//     stop in IDLE/DONE is ignored.
//   - start while RUN is ignored. Changes to div/burst_len/mode mid-run have no effect until the next start.
//   - Pulse counter saturates at its max in periodic mode (no wrap side-effects).
// CONFIGURATION
//   `TOGGLE_PULSE_GEN_SHADOW_Q_EN defined: q_shadow toggles on every edge where t_out=1, reset to 0 by rst.
//     This matches the Q of a downstream T flip-flop on the same clk/rst.
//   Undefined: q_shadow port and logic are absent.
// STRUCTURE
//   Package toggle_pulse_gen_pkg:
//     state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2); default CNT_W/LEN_W constants.
//   Sub-module toggle_prescaler: CNT_W down-counter with load/enable/reload and a 1-cycle tick output.
//   The top level holds the FSM, pulse counter, output registers and the optional shadow Q.
// TESTING
//   1. rst=1 for 3 cycles mid-run -> all outputs 0 next edge, state IDLE.
//   2. mode=1, div=4, burst_len=3, start at edge 10 -> t_out high in cycles 14, 18, 22; done in cycle 23; busy 10..22.
//   3. mode=0, div=0 -> t_out high every cycle; stop -> t_out=0 and busy=0 next edge, no done.
//   4. mode=0, div=5, en=0 for 7 cycles mid-period -> pulse delayed exactly 7 cycles, period otherwise unchanged.
//   5. mode=1, burst_len=0 -> done one cycle after start, zero t_out pulses; start during RUN ignored.
//   6. With SHADOW_Q_EN, burst_len=5 -> q_shadow ends at 1; matches a reference T flip-flop fed by t_out.

Source files
------------

// File: rtl/toggle_pulse_gen_pkg.sv
// Shared types and default widths for the toggle pulse generator.
package toggle_pulse_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/toggle_prescaler.sv
// Prescale down-counter: load sets the starting count, each enabled cycle
// decrements, and reaching zero reloads and raises tick for that cycle.
module toggle_prescaler
  import toggle_pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  input  logic [CNT_W-1:0] reload_val,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // tick is combinational so the top can register it straight into t_out.
  assign tick = run && (cnt == '0);

  // Count down while enabled; a pending load always wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run) begin
      cnt <= (cnt == '0) ? reload_val : (cnt - ONE);
    end
  end

endmodule

// File: rtl/toggle_pulse_gen.sv
// T-strobe generator for a downstream T flip-flop: divides clk by a run-time
// period and issues 1-cycle pulses, free-running or as a counted burst.
// Optional feature macro: TOGGLE_PULSE_GEN_SHADOW_Q_EN adds q_shadow, a copy
// of the downstream flip-flop Q.
module toggle_pulse_gen
  import toggle_pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] div,
  input  logic [LEN_W-1:0] burst_len,
  output logic             t_out,
  output logic             busy,
  output logic             done
`ifdef TOGGLE_PULSE_GEN_SHADOW_Q_EN
  ,
  output logic             q_shadow
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  // Pulse counter holds at all-ones so long periodic runs never wrap.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : (v + LEN_ONE);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] div_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pulse_cnt;
  logic             mode_q;

  logic             accept;
  logic             burst_end;
  logic             pre_run;
  logic             tick;
  logic [CNT_W-1:0] div_eff;

  // A zero period behaves as a period of one.
  assign div_eff   = (div == '0) ? CNT_ONE : div;
  assign accept    = (state == IDLE) && start && en;
  assign burst_end = mode_q && (pulse_cnt == len_q);
  // Prescaler advances only in an active, enabled RUN cycle that is neither
  // aborted nor the burst-completion cycle.
  assign pre_run   = (state == RUN) && en && !stop && !burst_end;

  toggle_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_val   (div_eff - CNT_ONE),
    .run        (pre_run),
    .reload_val (div_q - CNT_ONE),
    .tick       (tick)
  );

  // Run settings are captured at start and held for the whole run.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_q  <= div_eff;
      len_q  <= burst_len;
      mode_q <= mode;
    end
  end

  // Control FSM with registered strobe, busy and done; stop outranks a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      t_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          t_out <= 1'b0;
          done  <= 1'b0;
          if (accept) begin
            pulse_cnt <= '0;
            if (mode && (burst_len == '0)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            t_out <= 1'b0;
            busy  <= 1'b0;
          end else if (burst_end) begin
            state <= DONE;
            t_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            t_out <= tick;
            if (tick) begin
              pulse_cnt <= sat_inc(pulse_cnt);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          t_out <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          t_out <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TOGGLE_PULSE_GEN_SHADOW_Q_EN
  // Mirror of the downstream T flip-flop: toggle on every edge with t_out high.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_shadow <= 1'b0;
    end else if (t_out) begin
      q_shadow <= ~q_shadow;
    end
  end
`endif

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Scoreboard bench for toggle_pulse_gen: a cycle-level reference predicts
// t_out/busy/done(/q_shadow) for each edge, the prediction is queued when
// inputs are driven and popped when the DUT outputs are sampled.
module tb_toggle_pulse_gen;

  logic        clk = 1'b0;
  logic        rst, en, start, stop, mode;
  logic [15:0] div;
  logic [7:0]  burst_len;
  logic        t_out, busy, done;
  logic        qs;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_seen = 0;
  int done_seen = 0;
  int done_cyc = 0;
  int pulse_cyc[$];
  logic [3:0] exp_q[$];
  string phase = "init";

  // Reference model state
  int m_state = 0;
  int m_div = 1, m_len = 0, m_el = 0, m_pc = 0;
  bit m_mode = 0, m_t = 0, m_busy = 0, m_done = 0, m_q = 0;

  always #5 clk = ~clk;

  toggle_pulse_gen #(.CNT_W(16), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .burst_len (burst_len),
    .t_out     (t_out),
    .busy      (busy),
    .done      (done)
`ifdef TOGGLE_PULSE_GEN_SHADOW_Q_EN
    ,
    .q_shadow  (qs)
`endif
  );

`ifndef TOGGLE_PULSE_GEN_SHADOW_Q_EN
  assign qs = 1'b0;
`endif

  // Independent reference T flip-flop fed by the DUT strobe
  logic ref_q;
  always @(posedge clk) begin
    if (rst) ref_q <= 1'b0;
    else if (t_out) ref_q <= ~ref_q;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Predict registered outputs after the coming edge from the current inputs.
  task automatic model_edge();
    bit old_t;
    old_t = m_t;
    if (rst) begin
      m_state = 0; m_t = 0; m_busy = 0; m_done = 0; m_q = 0;
      m_el = 0; m_pc = 0;
      return;
    end
    if (old_t) m_q = ~m_q;
    case (m_state)
      0: begin
        m_t = 0; m_done = 0;
        if (start && en) begin
          m_div = (div == 16'd0) ? 1 : int'(div);
          m_len = int'(burst_len);
          m_mode = mode;
          m_el = 0; m_pc = 0;
          if (mode && burst_len == 8'd0) begin
            m_state = 2; m_done = 1; m_busy = 0;
          end else begin
            m_state = 1; m_busy = 1;
          end
        end
      end
      1: begin
        if (stop) begin
          m_state = 0; m_t = 0; m_busy = 0;
        end else if (m_mode && m_pc == m_len) begin
          m_state = 2; m_t = 0; m_busy = 0; m_done = 1;
        end else if (en) begin
          m_el++;
          if (m_el == m_div) begin
            m_t = 1; m_el = 0;
            if (m_pc < 255) m_pc++;
          end else begin
            m_t = 0;
          end
        end else begin
          m_t = 0;
        end
      end
      default: begin
        m_state = 0; m_t = 0; m_busy = 0; m_done = 0;
      end
    endcase
  endtask

  task automatic step();
    logic [3:0] e;
    bit eq;
    model_edge();
`ifdef TOGGLE_PULSE_GEN_SHADOW_Q_EN
    eq = m_q;
`else
    eq = 1'b0;
`endif
    exp_q.push_back({m_t, m_busy, m_done, eq});
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check_eq({phase, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq(phase, int'({t_out, busy, done, qs}), int'(e));
    end
    if (t_out) begin
      pulse_seen++;
      pulse_cyc.push_back(cyc);
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    pulse_seen = 0;
    done_seen = 0;
    done_cyc = -1;
    pulse_cyc.delete();
  endtask

  initial begin
    int s;
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    div = 16'd1; burst_len = 8'd0;

    // Reset state
    phase = "reset";
    steps(2);
    check_eq("reset_outs", int'({t_out, busy, done, qs}), 0);
    rst = 1'b0;
    steps(2);

    // Burst: div=4, len=3
    phase = "burst";
    clear_obs();
    mode = 1'b1; div = 16'd4; burst_len = 8'd3; start = 1'b1;
    step();
    s = cyc;
    start = 1'b0;
    check_eq("burst_busy_at_start", int'(busy), 1);
    div = 16'd7; burst_len = 8'd9; mode = 1'b0;
    steps(16);
    check_eq("burst_npulse", pulse_seen, 3);
    check_eq("burst_ndone", done_seen, 1);
    if (pulse_cyc.size() == 3) begin
      check_eq("burst_p0", pulse_cyc[0] - s, 4);
      check_eq("burst_p1", pulse_cyc[1] - s, 8);
      check_eq("burst_p2", pulse_cyc[2] - s, 12);
    end
    check_eq("burst_done_cyc", done_cyc - s, 13);

    // Periodic with div=0, then stop
    phase = "div0";
    clear_obs();
    mode = 1'b0; div = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    steps(5);
    check_eq("div0_npulse", pulse_seen, 5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("stop_outs", int'({t_out, busy}), 0);
    steps(3);
    check_eq("stop_no_done", done_seen, 0);

    // Zero-length burst; start in the DONE cycle is ignored
    phase = "len0";
    clear_obs();
    mode = 1'b1; burst_len = 8'd0; div = 16'd3; start = 1'b1;
    step();
    check_eq("len0_done", int'(done), 1);
    step();
    start = 1'b0;
    check_eq("len0_idle_after", int'({done, busy}), 0);
    steps(4);
    check_eq("len0_npulse", pulse_seen, 0);
    check_eq("len0_ndone", done_seen, 1);

    // Periodic div=5 with a 7-cycle pause; start during RUN ignored
    phase = "pause";
    clear_obs();
    mode = 1'b0; div = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    steps(7);
    en = 1'b0;
    steps(7);
    en = 1'b1;
    mode = 1'b1; burst_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0; mode = 1'b0;
    steps(14);
    check_eq("pause_npulse", pulse_cyc.size(), 4);
    if (pulse_cyc.size() == 4) begin
      check_eq("pause_gap0", pulse_cyc[1] - pulse_cyc[0], 12);
      check_eq("pause_gap1", pulse_cyc[2] - pulse_cyc[1], 5);
      check_eq("pause_gap2", pulse_cyc[3] - pulse_cyc[2], 5);
    end
    check_eq("pause_still_busy", int'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Mid-run reset held 3 cycles discards the run
    phase = "midrst";
    mode = 1'b0; div = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    steps(5);
    rst = 1'b1;
    steps(3);
    check_eq("midrst_outs", int'({t_out, busy, done, qs}), 0);
    rst = 1'b0;
    clear_obs();
    steps(5);
    check_eq("midrst_npulse", pulse_seen, 0);
    check_eq("midrst_busy", int'(busy), 0);

`ifdef TOGGLE_PULSE_GEN_SHADOW_Q_EN
    // Shadow Q over a 5-pulse burst
    phase = "shadow";
    rst = 1'b1;
    step();
    rst = 1'b0;
    mode = 1'b1; div = 16'd2; burst_len = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    steps(16);
    check_eq("shadow_final", int'(qs), 1);
    check_eq("shadow_vs_ref", int'(qs), int'(ref_q));
`endif

    // Long periodic div=1 run crosses pulse-counter saturation
    phase = "long";
    clear_obs();
    mode = 1'b0; div = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    steps(300);
    check_eq("long_npulse", pulse_seen, 300);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Random traffic against the reference
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      mode      = 1'($urandom_range(0, 1));
      div       = 16'($urandom_range(0, 4));
      burst_len = 8'($urandom_range(0, 4));
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
